// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory bus between the MEM pipeline stage and memory.
//
// Handshake: the master raises dmem_req and keeps it high, with stable
// dmem_addr / dmem_we / dmem_wdata, until the slave answers with a
// single-cycle dmem_ack pulse. dmem_rdata is meaningful only in the cycle
// where dmem_ack=1. While dmem_req=0 the master drives addr/we/wdata to 0.
//
// Signals:
//   dmem_req   master->slave  request strobe
//   dmem_we    master->slave  write strobe (store), qualified by dmem_req
//   dmem_addr  master->slave  16-bit word address
//   dmem_wdata master->slave  16-bit store data
//   dmem_rdata slave->master  16-bit load data
//   dmem_ack   slave->master  transfer-complete pulse
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with a request/ack data-memory port.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   enable          hazard freeze; 1 holds the MEM/WB register
//   pipline_reg_in  [37:0] EX/MEM register
//                   [37:22] ALU result/address, [21] mem_write,
//                   [20:5] store data, [4] reg_write, [3:1] dest, [0] load
//   pipline_reg_out [36:0] MEM/WB register
//                   [36:21] load data, [20:5] ALU result, [4:0] ctrl/dest
//   Mem_data        forwarding value (ALU result) to EX
//   mem_op_dest     destination index when reg_write=1, else 0
//   mem_stall       stall request to the hazard unit
//   o_dbg_state     current FSM state (IDLE=0, WAIT=1, DONE=2)
//   dmem            data-memory bus (master side)
//
// A memory access raises the request in IDLE, holds it in WAIT until the
// ack, and writes the result into the MEM/WB register on the ack edge. If
// the pipeline is frozen when the ack arrives, the read data is parked in a
// hold register and the FSM waits in DONE for the freeze to lift, so the
// access is never issued twice.
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [37:0]        pipline_reg_in,
  output logic [36:0]        pipline_reg_out,
  output logic [15:0]        Mem_data,
  output logic [2:0]         mem_op_dest,
  output logic               mem_stall,
  output logic [1:0]         o_dbg_state,
  mem_stage_if.master        dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [36:0] r_out;
  logic [15:0] r_hold;

  logic        w_store;
  logic        w_load;
  logic        w_access;
  logic        w_req;
  logic        w_update;
  logic [15:0] w_load_data;

  // mem_write wins when both mem_write and load are set.
  assign w_store  = pipline_reg_in[21];
  assign w_load   = pipline_reg_in[0] & ~pipline_reg_in[21];
  assign w_access = pipline_reg_in[21] | pipline_reg_in[0];

  // Request and stall are forced low during reset so an in-flight access
  // is abandoned immediately.
  assign w_req     = ~rst & (((r_state == S_IDLE) & w_access) | (r_state == S_WAIT));
  assign mem_stall = ~rst & (((r_state == S_IDLE) & w_access) |
                             ((r_state == S_WAIT) & ~dmem.dmem_ack));

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_req & w_store;
  assign dmem.dmem_addr  = w_req ? pipline_reg_in[37:22] : 16'h0000;
  assign dmem.dmem_wdata = w_req ? pipline_reg_in[20:5]  : 16'h0000;

  assign Mem_data    = pipline_reg_in[37:22];
  assign mem_op_dest = pipline_reg_in[4] ? pipline_reg_in[3:1] : 3'b000;

  assign w_update = ~enable & ~mem_stall;

  // Load-data field of the MEM/WB register: live read data on the ack
  // cycle, parked data when leaving DONE, zero for everything else.
  always_comb begin
    w_load_data = 16'h0000;
    case (r_state)
      S_WAIT:  if (w_load) w_load_data = dmem.dmem_rdata;
      S_DONE:  if (w_load) w_load_data = r_hold;
      default: w_load_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= 37'd0;
      r_hold  <= 16'h0000;
    end else begin
      if (w_update) begin
        r_out <= {w_load_data, pipline_reg_in[37:22], pipline_reg_in[4:0]};
      end
      case (r_state)
        S_IDLE: begin
          if (w_access) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            if (enable) begin
              r_hold  <= dmem.dmem_rdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (!enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pipline_reg_out = r_out;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed bench for mem_stage. Expected MEM/WB register
// values are pushed when an instruction is driven and popped on the edge
// where the stage should capture it; between captures the register is
// checked against the last expected value.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [37:0] pipline_reg_in;
  logic [36:0] pipline_reg_out;
  logic [15:0] Mem_data;
  logic [2:0]  mem_op_dest;
  logic        mem_stall;
  logic [1:0]  o_dbg_state;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .pipline_reg_in  (pipline_reg_in),
    .pipline_reg_out (pipline_reg_out),
    .Mem_data        (Mem_data),
    .mem_op_dest     (mem_op_dest),
    .mem_stall       (mem_stall),
    .o_dbg_state     (o_dbg_state),
    .dmem            (dmem_bus)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- scoreboard ----
  logic [36:0] exp_q[$];
  logic [36:0] last_out;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [36:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, pipline_reg_out);
    end else begin
      e = exp_q.pop_front();
      last_out = e;
      chk(tag, pipline_reg_out, e);
    end
  endtask

  // ---- driver helpers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [37:0] mk_in(input logic [15:0] alu, input logic mw,
                                        input logic [15:0] sd, input logic rw,
                                        input logic [2:0] dst, input logic ld);
    return {alu, mw, sd, rw, dst, ld};
  endfunction

  // ---- watchdog ----
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  // ---- stimulus ----
  initial begin
    logic [15:0] res;
    logic        rw;
    logic [2:0]  dst;

    vectors     = 0;
    miscompares = 0;
    last_out    = 37'd0;

    rst                 = 1'b1;
    enable              = 1'b0;
    pipline_reg_in      = mk_in(16'h0040, 1'b0, 16'h0, 1'b1, 3'd2, 1'b1);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 16'h0000;

    // Reset with a load present: request and stall are forced low.
    step();
    step();
    chk("rst_out",   pipline_reg_out, 37'd0);
    chk("rst_req",   dmem_bus.dmem_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_state", o_dbg_state, ST_IDLE);

    // ALU op, reg_write=1, dest=5, result 0x1234.
    rst            = 1'b0;
    pipline_reg_in = mk_in(16'h1234, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0);
    settle();
    chk("alu_stall", mem_stall, 1'b0);
    chk("alu_req",   dmem_bus.dmem_req, 1'b0);
    push_exp({16'h0000, 16'h1234, 5'b11010});
    step();
    check_out("alu_out");
    chk("alu_ctrl", pipline_reg_out[4:1], 4'b1101);

    // Load at 0x0040, ack 3 cycles after the request, rdata 0xBEEF.
    pipline_reg_in = mk_in(16'h0040, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1);
    settle();
    chk("ld_req0",   dmem_bus.dmem_req, 1'b1);
    chk("ld_we0",    dmem_bus.dmem_we, 1'b0);
    chk("ld_addr0",  dmem_bus.dmem_addr, 16'h0040);
    chk("ld_stall0", mem_stall, 1'b1);
    step();
    chk("ld_hold1",  pipline_reg_out, last_out);
    chk("ld_state1", o_dbg_state, ST_WAIT);
    chk("ld_stall1", mem_stall, 1'b1);
    chk("ld_req1",   dmem_bus.dmem_req, 1'b1);
    step();
    chk("ld_stall2", mem_stall, 1'b1);
    chk("ld_hold2",  pipline_reg_out, last_out);
    step();
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'hBEEF;
    settle();
    chk("ld_stall3", mem_stall, 1'b0);
    push_exp({16'hBEEF, 16'h0040, 5'b10101});
    step();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 16'h0000;
    check_out("ld_out");
    chk("ld_state_end", o_dbg_state, ST_IDLE);

    // Store at 0x0010, data 0x00AA, acked in the first WAIT cycle.
    pipline_reg_in = mk_in(16'h0010, 1'b1, 16'h00AA, 1'b0, 3'd0, 1'b0);
    settle();
    chk("st_req0",   dmem_bus.dmem_req, 1'b1);
    chk("st_we0",    dmem_bus.dmem_we, 1'b1);
    chk("st_wdata0", dmem_bus.dmem_wdata, 16'h00AA);
    chk("st_addr0",  dmem_bus.dmem_addr, 16'h0010);
    chk("st_stall0", mem_stall, 1'b1);
    step();
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'h7777;
    settle();
    chk("st_stall1", mem_stall, 1'b0);
    push_exp({16'h0000, 16'h0010, 5'b00000});
    step();
    dmem_bus.dmem_ack = 1'b0;
    check_out("st_out");

    // Back-to-back load, acked while frozen; enable drops 2 cycles later.
    pipline_reg_in = mk_in(16'h0020, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b1);
    settle();
    chk("b2b_req", dmem_bus.dmem_req, 1'b1);
    step();
    enable              = 1'b1;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'h5555;
    step();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 16'h0000;
    settle();
    chk("fz_state", o_dbg_state, ST_DONE);
    chk("fz_stall", mem_stall, 1'b0);
    chk("fz_req",   dmem_bus.dmem_req, 1'b0);
    chk("fz_hold",  pipline_reg_out, last_out);
    step();
    // A stray ack in DONE must not disturb the parked data.
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'hDEAD;
    settle();
    chk("fz_req2",   dmem_bus.dmem_req, 1'b0);
    chk("fz_state2", o_dbg_state, ST_DONE);
    step();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 16'h0000;
    enable              = 1'b0;
    settle();
    chk("fz_req3", dmem_bus.dmem_req, 1'b0);
    push_exp({16'h5555, 16'h0020, 5'b11001});
    step();
    check_out("fz_out");
    chk("fz_state_end", o_dbg_state, ST_IDLE);

    // Reset during WAIT, then a late ack.
    pipline_reg_in = mk_in(16'h0050, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1);
    step();
    step();
    rst = 1'b1;
    settle();
    chk("rw_req",   dmem_bus.dmem_req, 1'b0);
    chk("rw_we",    dmem_bus.dmem_we, 1'b0);
    chk("rw_stall", mem_stall, 1'b0);
    step();
    chk("rw_out",   pipline_reg_out, 37'd0);
    last_out = 37'd0;
    rst                 = 1'b0;
    enable              = 1'b1;
    pipline_reg_in      = 38'd0;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'hAAAA;
    settle();
    chk("rw_state", o_dbg_state, ST_IDLE);
    chk("rw_req2",  dmem_bus.dmem_req, 1'b0);
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("rw_state2", o_dbg_state, ST_IDLE);
    chk("rw_out2",   pipline_reg_out, last_out);
    enable = 1'b0;

    // mem_op_dest gating and Mem_data forwarding.
    pipline_reg_in = mk_in(16'h3C3C, 1'b0, 16'h0000, 1'b0, 3'd3, 1'b0);
    settle();
    chk("dest_rw0",  mem_op_dest, 3'd0);
    chk("fwd_0",     Mem_data, 16'h3C3C);
    pipline_reg_in = mk_in(16'hC3C3, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);
    settle();
    chk("dest_rw1",  mem_op_dest, 3'd3);
    chk("fwd_1",     Mem_data, 16'hC3C3);

    // Random non-memory ops: single-cycle pass-through.
    for (int i = 0; i < 6; i++) begin
      res = 16'($urandom_range(0, 16'hFFFF));
      rw  = 1'($urandom_range(0, 1));
      dst = 3'($urandom_range(0, 7));
      pipline_reg_in = mk_in(res, 1'b0, 16'($urandom_range(0, 16'hFFFF)), rw, dst, 1'b0);
      settle();
      chk("rnd_fwd",   Mem_data, res);
      chk("rnd_dest",  mem_op_dest, rw ? dst : 3'd0);
      chk("rnd_stall", mem_stall, 1'b0);
      push_exp({16'h0000, res, rw, dst, 1'b0});
      step();
      check_out("rnd_out");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
